// File: rtl/prim_ram_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prim_ram_fifo_pkg: shared types/helpers for the two-port RAM FIFO ctrl   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package prim_ram_fifo_pkg;

    localparam int OStageDepth = 2;

    typedef logic [1:0] ostage_cnt_t;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        ptr_inc = (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prim_ram_fifo_ostage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prim_ram_fifo_ostage: 2-entry registered output buffer, head at slot 0   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module prim_ram_fifo_ostage
    import prim_ram_fifo_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_clr,
    input  logic             i_in_valid,
    input  logic [Width-1:0] i_in_data,
    input  logic             i_pop,
    output ostage_cnt_t      o_cnt,
    output logic [Width-1:0] o_head
);

    ostage_cnt_t      r_cnt;
    ostage_cnt_t      w_cnt_nxt;
    ostage_cnt_t      w_wr_idx;
    logic [Width-1:0] r_d0;
    logic [Width-1:0] r_d1;
    logic [Width-1:0] w_d0_nxt;
    logic [Width-1:0] w_d1_nxt;

    // Pop shifts first, then the incoming word lands at the post-pop tail.
    always_comb begin
        w_d0_nxt  = r_d0;
        w_d1_nxt  = r_d1;
        w_cnt_nxt = r_cnt;
        w_wr_idx  = r_cnt;
        if (i_pop) begin
            w_d0_nxt  = r_d1;
            w_cnt_nxt = r_cnt - 2'd1;
            w_wr_idx  = r_cnt - 2'd1;
        end
        if (i_in_valid) begin
            if (w_wr_idx == 2'd0) begin
                w_d0_nxt = i_in_data;
            end else begin
                w_d1_nxt = i_in_data;
            end
            w_cnt_nxt = w_cnt_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_d0  <= w_d0_nxt;
            r_d1  <= w_d1_nxt;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_head = r_d0;

endmodule
`default_nettype wire

// File: rtl/prim_ram_2p_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prim_ram_2p_fifo_ctrl: FIFO controller for a 1W/1R RAM with 2-entry      |
// | prefetching output stage. Optional PRIM_RAM_FIFO_BYPASS_EN macro lets    |
// | pushes into an empty FIFO skip the RAM.                 Rev 1.0          |
// +--------------------------------------------------------------------------+
module prim_ram_2p_fifo_ctrl
    import prim_ram_fifo_pkg::*;
#(
    parameter  int Width = 32,
    parameter  int Depth = 128,
    localparam int Aw    = $clog2(Depth),
    localparam int DW    = $clog2(Depth + 3)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o,
    output logic [DW-1:0]    depth_o,
    output logic             full_o,
    output logic             ram_a_req_o,
    output logic             ram_a_write_o,
    output logic [Aw-1:0]    ram_a_addr_o,
    output logic [Width-1:0] ram_a_wdata_o,
    output logic             ram_b_req_o,
    output logic             ram_b_write_o,
    output logic [Aw-1:0]    ram_b_addr_o,
    output logic [Width-1:0] ram_b_wdata_o,
    input  logic [Width-1:0] ram_b_rdata_i
);

    localparam int            CW      = $clog2(Depth + 1);
    localparam logic [CW-1:0] c_depth = CW'(Depth);

    logic [Aw-1:0]    r_wptr;
    logic [Aw-1:0]    r_rptr;
    logic [CW-1:0]    r_ram_cnt;
    logic             r_inflight;
    logic [DW-1:0]    r_depth;

    logic             w_full;
    logic             w_ram_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic             w_ram_push;
    logic             w_issue;
    logic             w_room;
    logic [2:0]       w_occ;
    logic             w_os_in_valid;
    logic [Width-1:0] w_os_in_data;
    ostage_cnt_t      w_os_cnt;
    logic [Width-1:0] w_os_head;
    logic [Aw-1:0]    w_wptr_nxt;
    logic [Aw-1:0]    w_rptr_nxt;

    assign w_full      = (r_ram_cnt == c_depth);
    assign w_ram_empty = (r_ram_cnt == '0);
    assign wready_o    = !w_full && !clr_i;
    assign w_push      = wvalid_i && wready_o;
    assign w_pop       = (w_os_cnt != '0) && rready_i && !clr_i;

    // Slots already claimed in the output stage, net of this cycle's pop.
    assign w_occ   = {1'b0, w_os_cnt} + {2'b00, r_inflight};
    assign w_room  = (w_occ < (3'(OStageDepth) + {2'b00, w_pop}));
    assign w_issue = !w_ram_empty && w_room && !clr_i;

`ifdef PRIM_RAM_FIFO_BYPASS_EN
    // With nothing queued ahead of it, a push may go straight to the output stage.
    assign w_bypass      = w_push && w_ram_empty && !r_inflight && w_room;
    assign w_os_in_valid = (r_inflight || w_bypass) && !clr_i;
    assign w_os_in_data  = r_inflight ? ram_b_rdata_i : wdata_i;
`else
    assign w_bypass      = 1'b0;
    assign w_os_in_valid = r_inflight && !clr_i;
    assign w_os_in_data  = ram_b_rdata_i;
`endif

    assign w_ram_push = w_push && !w_bypass;

    assign w_wptr_nxt = Aw'(ptr_inc(32'(r_wptr), 32'(Depth)));
    assign w_rptr_nxt = Aw'(ptr_inc(32'(r_rptr), 32'(Depth)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_depth    <= '0;
        end else if (clr_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_depth    <= '0;
        end else begin
            if (w_ram_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_issue) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_ram_push, w_issue})
                2'b10:   r_ram_cnt <= r_ram_cnt + CW'(1);
                2'b01:   r_ram_cnt <= r_ram_cnt - CW'(1);
                default: r_ram_cnt <= r_ram_cnt;
            endcase
            r_inflight <= w_issue;
            // Every entry enters by a push and leaves by a pop, wherever it sits.
            r_depth    <= r_depth + DW'(w_push) - DW'(w_pop);
        end
    end

    prim_ram_fifo_ostage #(
        .Width (Width)
    ) u_ostage (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_clr      (clr_i),
        .i_in_valid (w_os_in_valid),
        .i_in_data  (w_os_in_data),
        .i_pop      (w_pop),
        .o_cnt      (w_os_cnt),
        .o_head     (w_os_head)
    );

    assign rvalid_o = (w_os_cnt != '0);
    assign rdata_o  = w_os_head;
    assign depth_o  = r_depth;
    assign full_o   = w_full;

    assign ram_a_req_o   = w_ram_push;
    assign ram_a_write_o = w_ram_push;
    assign ram_a_addr_o  = r_wptr;
    assign ram_a_wdata_o = wdata_i;

    assign ram_b_req_o   = w_issue;
    assign ram_b_write_o = 1'b0;
    assign ram_b_addr_o  = r_rptr;
    assign ram_b_wdata_o = '0;

endmodule
`default_nettype wire

// File: tb/tb_prim_ram_2p_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prim_ram_2p_fifo_ctrl: controller + behavioural 2-port RAM, Depth=4   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_prim_ram_2p_fifo_ctrl;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int AW = 2;
    localparam int DWW = 3;
`ifdef PRIM_RAM_FIFO_BYPASS_EN
    localparam int LAT      = 1;
    localparam int HOLD_AGE = 1;
`else
    localparam int LAT      = 3;
    localparam int HOLD_AGE = 2;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr = 1'b0;
    logic           wvalid = 1'b0;
    logic           rready = 1'b0;
    logic [W-1:0]   wdata = '0;

    logic           wready_o, rvalid_o, full_o;
    logic [W-1:0]   rdata_o;
    logic [DWW-1:0] depth_o;
    logic           ram_a_req, ram_a_write, ram_b_req, ram_b_write;
    logic [AW-1:0]  ram_a_addr, ram_b_addr;
    logic [W-1:0]   ram_a_wdata, ram_b_wdata, ram_b_rdata;

    always #5 clk = ~clk;

    prim_ram_2p_fifo_ctrl #(.Width(W), .Depth(D)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wvalid_i(wvalid), .wready_o(wready_o), .wdata_i(wdata),
        .rvalid_o(rvalid_o), .rready_i(rready), .rdata_o(rdata_o),
        .depth_o(depth_o), .full_o(full_o),
        .ram_a_req_o(ram_a_req), .ram_a_write_o(ram_a_write),
        .ram_a_addr_o(ram_a_addr), .ram_a_wdata_o(ram_a_wdata),
        .ram_b_req_o(ram_b_req), .ram_b_write_o(ram_b_write),
        .ram_b_addr_o(ram_b_addr), .ram_b_wdata_o(ram_b_wdata),
        .ram_b_rdata_i(ram_b_rdata)
    );

    // Two-port RAM stand-in: write on A, registered read on B.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (ram_a_req && ram_a_write) mem[ram_a_addr] <= ram_a_wdata;
        if (ram_b_req) ram_b_rdata <= mem[ram_b_addr];
    end

    // Model: an ordered list of entries stamped with their push cycle.
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] stamp;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] got[$];
    logic [31:0] expq[$];
    logic [31:0] cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;

    function automatic int held_cnt();
        int n = 0;
        foreach (mq[i]) if (cyc - mq[i].stamp >= HOLD_AGE) n++;
        return (n > 2) ? 2 : n;
    endfunction

    function automatic logic m_rvalid();
        return (mq.size() != 0) && (cyc - mq[0].stamp >= LAT);
    endfunction

    function automatic logic m_full();
        return (mq.size() - held_cnt()) == D;
    endfunction

    function automatic logic m_wready();
        return !m_full() && !clr;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_got(input string nm);
        chk({nm, "_count"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            chk(nm, 64'(got[i]), 64'(expq[i]));
        end
        got.delete();
        expq.delete();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Model update on each clock edge / reset.
    initial begin
        logic do_pop, do_push;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
            end else begin
                if (clr) begin
                    mq.delete();
                end else begin
                    do_pop  = rready && m_rvalid();
                    do_push = wvalid && m_wready();
                    if (do_pop) void'(mq.pop_front());
                    if (do_push) mq.push_back('{data: wdata, stamp: cyc});
                end
                cyc++;
            end
        end
    end

    // Every-cycle comparison against the model, plus pop capture.
    initial begin
        forever begin
            @(negedge clk);
            chk("rvalid", 64'(rvalid_o), 64'(m_rvalid()));
            if (m_rvalid()) chk("rdata", 64'(rdata_o), 64'(mq[0].data));
            chk("depth", 64'(depth_o), 64'(mq.size()));
            chk("full", 64'(full_o), 64'(m_full()));
            chk("wready", 64'(wready_o), 64'(m_wready()));
            if (!rst_n) chk("rst_rdata", 64'(rdata_o), 64'd0);
            if (rst_n && rvalid_o && rready && !clr) got.push_back(rdata_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        next_cycle();
        next_cycle();

        // Idle after reset
        @(negedge clk);
        chk("idle_a_req", 64'(ram_a_req), 64'd0);
        chk("idle_b_req", 64'(ram_b_req), 64'd0);
        chk("idle_b_write", 64'(ram_b_write), 64'd0);
        chk("idle_rvalid", 64'(rvalid_o), 64'd0);
        chk("idle_wready", 64'(wready_o), 64'd1);
        chk("idle_depth", 64'(depth_o), 64'd0);
        next_cycle();

        // Single push of 0xA5
        wdata = 32'hA5;
        wvalid = 1'b1;
        @(negedge clk);
        chk("t1_a_req", 64'(ram_a_req), 64'(LAT == 3));
        chk("t1_a_addr", 64'(ram_a_addr), 64'd0);
        next_cycle();
        wvalid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t1_rvalid", 64'(rvalid_o), 64'(c >= LAT));
            chk("t1_b_req", 64'(ram_b_req), 64'((c == 1) && (LAT == 3)));
        end
        chk("t1_rdata", 64'(rdata_o), 64'hA5);
        chk("t1_depth", 64'(depth_o), 64'd1);
        next_cycle();
        rready = 1'b1;
        next_cycle();
        rready = 1'b0;
        next_cycle();
        expq.push_back(32'hA5);
        check_got("t1_pop");

        // Fill with 1..6, then drain with zero wait states
        for (int i = 1; i <= 6; i++) begin
            wdata = 32'(i);
            wvalid = 1'b1;
            @(negedge clk);
            chk("t2_wready", 64'(wready_o), 64'd1);
            next_cycle();
        end
        wvalid = 1'b0;
        @(negedge clk);
        chk("t2_wready_low", 64'(wready_o), 64'd0);
        chk("t2_full", 64'(full_o), 64'd1);
        chk("t2_depth", 64'(depth_o), 64'd6);
        next_cycle();
        rready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t2_pop_valid", 64'(rvalid_o), 64'd1);
            next_cycle();
        end
        rready = 1'b0;
        next_cycle();
        for (int i = 1; i <= 6; i++) expq.push_back(32'(i));
        check_got("t2_pop");

        // Steady stream 0..19
        rready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wdata = 32'(i);
            wvalid = 1'b1;
            @(negedge clk);
            if (i >= LAT) begin
                chk("t3_rvalid", 64'(rvalid_o), 64'd1);
                chk("t3_depth", 64'(depth_o), 64'(LAT));
            end
            next_cycle();
        end
        wvalid = 1'b0;
        repeat (6) next_cycle();
        rready = 1'b0;
        for (int i = 0; i < 20; i++) expq.push_back(32'(i));
        check_got("t3_pop");

        // Fill to 3 then flush while a read is in flight
        for (int i = 0; i < 3; i++) begin
            wdata = 32'h10 + 32'(i);
            wvalid = 1'b1;
            next_cycle();
        end
        wdata = 32'h99;
        wvalid = 1'b1;
        rready = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        chk("t4_clr_wready", 64'(wready_o), 64'd0);
        next_cycle();
        clr = 1'b0;
        wvalid = 1'b0;
        rready = 1'b0;
        @(negedge clk);
        chk("t4_depth", 64'(depth_o), 64'd0);
        chk("t4_rvalid", 64'(rvalid_o), 64'd0);
        next_cycle();
        wdata = 32'h77;
        wvalid = 1'b1;
        next_cycle();
        wvalid = 1'b0;
        rready = 1'b1;
        repeat (6) next_cycle();
        rready = 1'b0;
        expq.push_back(32'h77);
        check_got("t4_pop");

        // Reset with 5 entries held
        for (int i = 0; i < 5; i++) begin
            wdata = 32'h20 + 32'(i);
            wvalid = 1'b1;
            next_cycle();
        end
        wvalid = 1'b0;
        @(negedge clk);
        chk("t5_depth_pre", 64'(depth_o), 64'd5);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rvalid", 64'(rvalid_o), 64'd0);
        chk("t5_depth", 64'(depth_o), 64'd0);
        chk("t5_full", 64'(full_o), 64'd0);
        chk("t5_wready", 64'(wready_o), 64'd1);
        chk("t5_rdata", 64'(rdata_o), 64'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        wdata = 32'h55;
        wvalid = 1'b1;
        next_cycle();
        wvalid = 1'b0;
        rready = 1'b1;
        repeat (6) next_cycle();
        rready = 1'b0;
        expq.push_back(32'h55);
        check_got("t5_pop");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
